// File: rtl/alu_issue_stage.sv
// Purpose : request FIFO + issue sequencer feeding a clocked 8-bit ALU, with result/accumulator capture.
// Latency : a request pops 1 edge after push; ALU inputs are valid after the pop edge; result is captured ALU_LAT+1 edges after pop.
// Backpres: in_ready drops while the FIFO is full; a pending result (res_valid && !res_ready) stalls further issue.
//
// Ports:
//   clk, rst                                - clock (rising edge), async active-high reset
//   in_valid/in_ready, in_a, in_b,
//   in_opcode, in_use_acc                   - request push side (use_acc swaps A for acc at issue)
//   alu_a, alu_b, alu_opcode                - registered operands to the ALU
//   alu_result                              - ALU_Out
//   res_valid/res_ready, res_data           - captured result handshake
//   acc                                     - last captured result
//   busy                                    - sequencer active or requests queued

// Purpose : generic pointer-based FIFO, wrap bit distinguishes full from empty.
// Latency : first-word-fall-through, rdata valid whenever !empty.
// Backpres: push ignored when full, pop ignored when empty.
module alu_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_en;
    logic         pop_en;

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: only entries written since reset are ever read.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module alu_issue_stage #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic              in_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [DATA_W-1:0] acc,
    output logic              busy
);
    typedef struct packed {
        logic              use_acc;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } req_t;

    localparam int REQ_W = $bits(req_t);
    localparam int CNT_W = $clog2(ALU_LAT + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    req_t             wr_req;
    req_t             rd_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign wr_req   = {in_use_acc, in_opcode, in_b, in_a};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // res_valid is always 0 in IDLE, kept in the term so the stall reason stays explicit.
    assign pop      = (state == IDLE) && !fifo_empty && !res_valid;
    assign busy     = (state != IDLE) || !fifo_empty;

    alu_issue_fifo #(
        .W     (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_req),
        .rdata (rd_req),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            acc        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        // Chaining reads acc as it stands at the issue edge.
                        alu_a      <= rd_req.use_acc ? acc : rd_req.a;
                        alu_b      <= rd_req.b;
                        alu_opcode <= rd_req.opcode;
                        lat_cnt    <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter reaches ALU_LAT one edge after the ALU sampled our
                    // operands plus ALU_LAT-1, so ALU_Out is settled when captured.
                    if (lat_cnt == CNT_W'(ALU_LAT)) begin
                        res_data  <= alu_result;
                        acc       <= alu_result;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [3:0] in_opcode;
    logic       in_use_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [7:0] acc;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_stage #(
        .DATA_W  (8),
        .OP_W    (4),
        .DEPTH   (4),
        .ALU_LAT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .in_use_acc (in_use_acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .acc        (acc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocked ALU stand-in, one edge of latency.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1111: return (a < b) ? 8'd1 : 8'd0;
            default: return a ^ b;
        endcase
    endfunction

    initial alu_result = 8'h00;
    always @(posedge clk) alu_result <= alu_f(alu_a, alu_b, alu_opcode);

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       use_acc;
        logic [7:0] exp_alu_a;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic ua);
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_opcode  = op;
        in_use_acc = ua;
    endtask

    task automatic wait_res(input string name, input int budget);
        int n;
        n = 0;
        while (!res_valid && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, res_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic       seen;
        int         accepted;
        logic [7:0] acc_before;

        vecs[0] = '{8'hAA, 8'd7,   4'h0, 1'b1, 8'd0,   8'd7};
        vecs[1] = '{8'd10, 8'd5,   4'hF, 1'b0, 8'd10,  8'd0};
        vecs[2] = '{8'd1,  8'd1,   4'hF, 1'b0, 8'd1,   8'd0};
        vecs[3] = '{8'd2,  8'd25,  4'hF, 1'b0, 8'd2,   8'd1};
        vecs[4] = '{8'hAA, 8'd1,   4'hF, 1'b1, 8'd1,   8'd0};
        vecs[5] = '{8'd200,8'd100, 4'h0, 1'b0, 8'd200, 8'd44};
        vecs[6] = '{8'hAA, 8'd6,   4'h0, 1'b1, 8'd44,  8'd50};
        vecs[7] = '{8'd5,  8'd9,   4'h1, 1'b0, 8'd5,   8'd252};
        vecs[8] = '{8'hAA, 8'd3,   4'h1, 1'b1, 8'd252, 8'd249};
        vecs[9] = '{8'd3,  8'd5,   4'h2, 1'b0, 8'd3,   8'd6};

        // ---------------- reset state ----------------
        rst       = 1'b1;
        res_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        tick();
        tick();
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_acc", acc, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // ---------------- table: one request at a time ----------------
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].use_acc);
            tick();
            drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
            wait_res($sformatf("vec%0d", i), 10);
            check($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].exp_alu_a);
            check($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].b);
            check($sformatf("vec%0d_alu_opcode", i), alu_opcode, vecs[i].op);
            check($sformatf("vec%0d_res_data", i), res_data, vecs[i].exp_res);
            check($sformatf("vec%0d_acc", i), acc, vecs[i].exp_res);
            tick();
            check($sformatf("vec%0d_res_valid_clr", i), res_valid, 0);
            check($sformatf("vec%0d_acc_hold", i), acc, vecs[i].exp_res);
        end
        tick();

        // ---------------- single request, exact timing ----------------
        drive(1'b1, 8'd10, 8'd5, 4'hF, 1'b0);
        tick();                                    // push edge
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        check("single_busy_queued", busy, 1);
        check("single_alu_a_idle_hold", alu_a, 3);
        tick();                                    // pop edge
        check("single_alu_a", alu_a, 10);
        check("single_alu_b", alu_b, 5);
        check("single_alu_opcode", alu_opcode, 4'hF);
        check("single_valid_pop", res_valid, 0);
        tick();
        check("single_valid_pop1", res_valid, 0);
        tick();                                    // capture edge
        check("single_valid_pop2", res_valid, 1);
        check("single_res_data", res_data, 0);
        check("single_acc", acc, 0);
        tick();                                    // handshake edge
        check("single_valid_clr", res_valid, 0);
        check("single_busy_done", busy, 0);
        tick();

        // ---------------- back-to-back, res_ready high ----------------
        drive(1'b1, 8'd1, 8'd1, 4'hF, 1'b0);
        tick();
        drive(1'b1, 8'd2, 8'd25, 4'hF, 1'b0);
        tick();                                    // second push, first pop
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        check("b2b_first_alu_a", alu_a, 1);
        tick();
        tick();                                    // first capture
        check("b2b_first_valid", res_valid, 1);
        check("b2b_first_res", res_data, 0);
        check("b2b_no_early_issue", alu_a, 1);
        tick();
        tick();
        check("b2b_second_alu_a", alu_a, 2);
        check("b2b_second_alu_b", alu_b, 25);
        wait_res("b2b_second", 10);
        check("b2b_second_res", res_data, 1);
        tick();
        tick();

        // ---------------- backpressure ----------------
        res_ready = 1'b0;
        drive(1'b1, 8'd1, 8'd1, 4'hF, 1'b0);
        tick();
        drive(1'b1, 8'd2, 8'd25, 4'hF, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        tick();
        tick();
        check("bp_first_valid", res_valid, 1);
        check("bp_first_res", res_data, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", k), res_valid, 1);
            check($sformatf("bp_hold%0d_res", k), res_data, 0);
            check($sformatf("bp_hold%0d_alu_a", k), alu_a, 1);
        end
        res_ready = 1'b1;
        tick();                                    // handshake
        check("bp_valid_clr", res_valid, 0);
        tick();                                    // second issue
        check("bp_second_alu_a", alu_a, 2);
        wait_res("bp_second", 10);
        check("bp_second_res", res_data, 1);
        tick();
        tick();

        // ---------------- FIFO full / wrap ----------------
        res_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(i * 10), 8'd1, 4'h0, 1'b0);
            if (in_ready) accepted++;
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        check("full_accepted", accepted, 5);
        check("full_in_ready", in_ready, 0);
        check("full_first_valid", res_valid, 1);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_res($sformatf("full_res%0d", i), 20);
            check($sformatf("full_res%0d_data", i), res_data, i * 10 + 1);
            tick();
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("full_dropped_extra", seen, 0);
        check("full_busy_done", busy, 0);
        check("full_in_ready_done", in_ready, 1);

        // ---------------- reset mid-WAIT ----------------
        acc_before = acc;
        check("rst_mid_acc_before", acc_before, 41);
        drive(1'b1, 8'd200, 8'd100, 4'h0, 1'b0);
        tick();
        drive(1'b1, 8'd7, 8'd7, 4'h3, 1'b0);
        tick();                                    // first in WAIT, second queued
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        check("rst_mid_alu_a_pre", alu_a, 200);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_alu_a", alu_a, 0);
        check("rst_mid_alu_b", alu_b, 0);
        check("rst_mid_alu_opcode", alu_opcode, 0);
        check("rst_mid_res_data", res_data, 0);
        check("rst_mid_acc", acc, 0);
        check("rst_mid_res_valid", res_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 1);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("rst_mid_no_result", seen, 0);
        check("rst_mid_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
